md_issue_ctrl: RTL and testbench

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_issue_pkg.sv | 25 ++
 rtl/md_perf_cnt.sv | 25 ++
 rtl/md_issue_ctrl.sv | 111 +++++++++++
 tb/tb_md_issue_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_issue_pkg.sv
// Shared encodings for the multiply/divide issue controller: op codes,
// idle codes and FSM state encodings.
package md_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } md_state_e;

  localparam logic [3:0] OP_MULTU = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MADD  = 4'b0100;
  localparam logic [3:0] OP_MADDU = 4'b0101;
  localparam logic [3:0] OP_MSUB  = 4'b0110;
  localparam logic [3:0] OP_MSUBU = 4'b0111;

  localparam logic [3:0] MULOP_IDLE  = 4'b1111;
  localparam logic [1:0] MTHILO_LO   = 2'b00;
  localparam logic [1:0] MTHILO_HI   = 2'b01;
  localparam logic [1:0] MTHILO_IDLE = 2'b11;

endpackage

// File: rtl/md_perf_cnt.sv
// Saturating event counter: counts cycles with inc=1 and sticks at all ones.
module md_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] val);
    if (val == {W{1'b1}}) return val;
    return val + {{(W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (reset)    r_count <= '0;
    else if (inc) r_count <= sat_inc(r_count);
  end

  assign count = r_count;

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: presents each op for
// one cycle, stalls md-class D-stage instructions, and flags protocol errors.
module md_issue_ctrl
  import md_issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic             e_md_start,
  input  logic [3:0]       e_md_op,
  input  logic             e_mt_lo,
  input  logic             e_mt_hi,
  input  logic [31:0]      e_srca,
  input  logic [31:0]      e_srcb,
  input  logic             d_uses_md,
  input  logic             flush,
  input  logic             md_busy,
  output logic [3:0]       md_mulop,
  output logic [1:0]       md_mthilo,
  output logic [31:0]      md_srca,
  output logic [31:0]      md_srcb,
  output logic             stall_d,
  output logic [CNT_W-1:0] busy_cycles,
  output logic             proto_err
);

  md_state_e   r_state, w_state_nxt;
  logic        r_wait_first, w_wait_first_nxt;
  logic        r_is_start;
  logic [3:0]  r_mulop;
  logic [1:0]  r_mthilo;
  logic [31:0] r_srca, r_srcb;
  logic        r_proto_err;
  logic        w_md_req, w_accept;

  assign w_md_req = e_valid & ~flush & (e_md_start | e_mt_lo | e_mt_hi);
  assign w_accept = w_md_req & (r_state == ST_IDLE) & ~md_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wait_first <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_first <= w_wait_first_nxt;
    end
  end

  // WAIT always spends its first cycle before looking at md_busy, covering
  // the gap before the unit raises busy.
  always_comb begin
    w_state_nxt      = r_state;
    w_wait_first_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (r_is_start) begin
          w_state_nxt      = ST_WAIT;
          w_wait_first_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT:  if (!r_wait_first && !md_busy) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Issue stage: op codes fall back to idle every cycle unless a new accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mulop     <= MULOP_IDLE;
      r_mthilo    <= MTHILO_IDLE;
      r_srca      <= '0;
      r_srcb      <= '0;
      r_is_start  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_mulop  <= MULOP_IDLE;
      r_mthilo <= MTHILO_IDLE;
      if (w_accept) begin
        r_is_start <= e_md_start;
        r_srca     <= e_srca;
        if (e_md_start) begin
          r_mulop <= e_md_op;
          r_srcb  <= e_srcb;
        end else begin
          r_mthilo <= e_mt_lo ? MTHILO_LO : MTHILO_HI;
        end
      end
      if (w_md_req && (r_state != ST_IDLE || md_busy)) r_proto_err <= 1'b1;
    end
  end

  md_perf_cnt #(.W(CNT_W)) u_perf_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (md_busy),
    .count (busy_cycles)
  );

  assign stall_d   = d_uses_md & (w_accept | (r_state != ST_IDLE) | md_busy);
  assign md_mulop  = r_mulop;
  assign md_mthilo = r_mthilo;
  assign md_srca   = r_srca;
  assign md_srcb   = r_srcb;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: issue timing, stalls, flush, protocol
// errors, reset abandonment and counter saturation.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        e_valid, e_md_start, e_mt_lo, e_mt_hi, d_uses_md, flush;
  logic        md_busy, md_busy2;
  logic [3:0]  e_md_op;
  logic [31:0] e_srca, e_srcb;

  logic [3:0]  md_mulop, md_mulop2;
  logic [1:0]  md_mthilo, md_mthilo2;
  logic [31:0] md_srca, md_srcb, md_srca2, md_srcb2;
  logic        stall_d, stall_d2, proto_err, proto_err2;
  logic [15:0] busy_cycles;
  logic [3:0]  busy_cycles2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md_issue_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_start(e_md_start),
    .e_md_op(e_md_op), .e_mt_lo(e_mt_lo), .e_mt_hi(e_mt_hi),
    .e_srca(e_srca), .e_srcb(e_srcb), .d_uses_md(d_uses_md), .flush(flush),
    .md_busy(md_busy), .md_mulop(md_mulop), .md_mthilo(md_mthilo),
    .md_srca(md_srca), .md_srcb(md_srcb), .stall_d(stall_d),
    .busy_cycles(busy_cycles), .proto_err(proto_err)
  );

  md_issue_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset2), .e_valid(e_valid), .e_md_start(e_md_start),
    .e_md_op(e_md_op), .e_mt_lo(e_mt_lo), .e_mt_hi(e_mt_hi),
    .e_srca(e_srca), .e_srcb(e_srcb), .d_uses_md(d_uses_md), .flush(flush),
    .md_busy(md_busy2), .md_mulop(md_mulop2), .md_mthilo(md_mthilo2),
    .md_srca(md_srca2), .md_srcb(md_srcb2), .stall_d(stall_d2),
    .busy_cycles(busy_cycles2), .proto_err(proto_err2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_e();
    e_valid = 0; e_md_start = 0; e_mt_lo = 0; e_mt_hi = 0; flush = 0;
    e_md_op = 4'b0000; e_srca = '0; e_srcb = '0;
  endtask

  initial begin
    clear_e();
    reset = 1; reset2 = 1; d_uses_md = 0; md_busy = 0; md_busy2 = 0;
    tick(); tick();
    reset = 0; reset2 = 0; d_uses_md = 1;
    settle();
    check("rst_mulop", md_mulop, 4'b1111);
    check("rst_mthilo", md_mthilo, 2'b11);
    check("rst_srca", md_srca, 32'd0);
    check("rst_srcb", md_srcb, 32'd0);
    check("rst_busycnt", busy_cycles, 16'd0);
    check("rst_perr", proto_err, 1'b0);
    check("rst_stall", stall_d, 1'b0);

    // mult 7*6 in E (cycle N) with mflo in D
    tick();
    e_valid = 1; e_md_start = 1; e_md_op = 4'b0001; e_srca = 32'd7; e_srcb = 32'd6;
    settle();
    check("mult_stall_N", stall_d, 1'b1);
    tick();  // N+1
    clear_e();
    settle();
    check("mult_mulop_N1", md_mulop, 4'b0001);
    check("mult_srca", md_srca, 32'd7);
    check("mult_srcb", md_srcb, 32'd6);
    check("mult_stall_N1", stall_d, 1'b1);
    for (int i = 2; i <= 6; i++) begin
      tick();
      md_busy = 1;
      settle();
      check("mult_mulop_busy", md_mulop, 4'b1111);
      check("mult_stall_busy", stall_d, 1'b1);
    end
    check("mult_cnt_N6", busy_cycles, 16'd4);
    tick();  // N+7
    md_busy = 0;
    settle();
    check("mult_cnt_N7", busy_cycles, 16'd5);
    check("mult_srca_hold", md_srca, 32'd7);
    tick();  // N+8
    settle();
    check("mult_idle_stall", stall_d, 1'b0);
    check("mult_perr", proto_err, 1'b0);

    // mthi 0xDEADBEEF with mfhi in D
    tick();
    e_valid = 1; e_mt_hi = 1; e_srca = 32'hDEADBEEF; e_srcb = 32'h11111111;
    settle();
    check("mthi_stall_M", stall_d, 1'b1);
    tick();
    clear_e();
    settle();
    check("mthi_code", md_mthilo, 2'b01);
    check("mthi_srca", md_srca, 32'hDEADBEEF);
    check("mthi_srcb_hold", md_srcb, 32'd6);
    check("mthi_mulop", md_mulop, 4'b1111);
    check("mthi_stall_M1", stall_d, 1'b1);
    tick();
    settle();
    check("mthi_stall_M2", stall_d, 1'b0);
    check("mthi_code_idle", md_mthilo, 2'b11);

    // mtlo
    tick();
    e_valid = 1; e_mt_lo = 1; e_srca = 32'h1234;
    tick();
    clear_e();
    settle();
    check("mtlo_code", md_mthilo, 2'b00);
    check("mtlo_srca", md_srca, 32'h1234);
    tick();

    // start takes priority over move; non-md D instruction never stalled
    tick();
    e_valid = 1; e_md_start = 1; e_mt_lo = 1; e_md_op = 4'b0010;
    e_srca = 32'hA; e_srcb = 32'hB;
    tick();  // ISSUE
    clear_e();
    d_uses_md = 0;
    settle();
    check("prio_mulop", md_mulop, 4'b0010);
    check("prio_mthilo", md_mthilo, 2'b11);
    check("nonmd_stall", stall_d, 1'b0);
    tick();  // WAIT first
    d_uses_md = 1;
    settle();
    check("prio_wait_stall", stall_d, 1'b1);
    tick();  // WAIT, busy=0 -> leaves
    settle();
    check("prio_wait2_stall", stall_d, 1'b1);
    tick();
    settle();
    check("prio_idle_stall", stall_d, 1'b0);

    // flushed div
    tick();
    e_valid = 1; e_md_start = 1; e_md_op = 4'b0010; flush = 1; d_uses_md = 0;
    tick();
    clear_e();
    d_uses_md = 1;
    settle();
    check("flush_mulop", md_mulop, 4'b1111);
    check("flush_idle", stall_d, 1'b0);
    check("flush_perr", proto_err, 1'b0);
    check("flush_srca_hold", md_srca, 32'hA);

    // reset in WAIT
    tick();
    e_valid = 1; e_md_start = 1; e_md_op = 4'b0001; e_srca = 32'h99;
    tick();
    clear_e();
    tick();
    md_busy = 1;
    tick();
    reset = 1; md_busy = 0;
    tick();
    reset = 0;
    settle();
    check("rstw_stall", stall_d, 1'b0);
    check("rstw_cnt", busy_cycles, 16'd0);
    check("rstw_srca", md_srca, 32'd0);
    tick();
    settle();
    check("rstw_stall2", stall_d, 1'b0);
    check("rstw_mulop", md_mulop, 4'b1111);

    // E mult while unit busy -> protocol error, no issue
    tick();
    md_busy = 1;
    e_valid = 1; e_md_start = 1; e_md_op = 4'b0001; e_srca = 32'h55;
    settle();
    check("perr_stall", stall_d, 1'b1);
    tick();
    clear_e();
    md_busy = 0;
    settle();
    check("perr_mulop", md_mulop, 4'b1111);
    check("perr_srca", md_srca, 32'd0);
    check("perr_set", proto_err, 1'b1);
    check("perr_idle", stall_d, 1'b0);
    tick(); tick();
    settle();
    check("perr_sticky", proto_err, 1'b1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    settle();
    check("perr_cleared", proto_err, 1'b0);

    // 4-bit counter saturation
    check("sat_start", busy_cycles2, 4'd0);
    tick();
    md_busy2 = 1;
    repeat (20) tick();
    md_busy2 = 0;
    settle();
    check("sat_15", busy_cycles2, 4'd15);
    tick();
    settle();
    check("sat_hold", busy_cycles2, 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
